// File: rtl/draw_pkg.sv
// Shared widths, request struct and FSM encoding for the draw request queue.
package draw_pkg;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } draw_req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_BLOCK,
        S_ISSUE_CLEAR,
        S_WAIT_ACK,
        S_WAIT_DONE
    } draw_state_t;
endpackage

// File: rtl/draw_fifo.sv
// Synchronous FIFO of draw requests; DEPTH must be a power of two so pointers wrap freely.
module draw_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  draw_req_t                i_wdata,
    input  logic                     i_pop,
    output draw_req_t                o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    draw_req_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only safe when a pop frees the slot on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/draw_request_queue.sv
// Queues block-draw requests and issues start/clear pulses to the square plotter.
// Optional screen-clear path is built when DRAW_QUEUE_CLEAR_EN is defined.
module draw_request_queue
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [X_W-1:0]         req_x,
    input  logic [Y_W-1:0]         req_y,
    input  logic [COL_W-1:0]       req_colour,
    input  logic                   clear_req,
    input  logic                   ready_to_draw,
    output logic                   enable_start,
    output logic                   enable_clear,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [COL_W-1:0]       colour,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    draw_state_t r_state;
    draw_state_t w_next_state;
    draw_req_t   w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_idle_go;
    logic        w_take_clear;
    logic        w_clr_busy;

    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_idle_go = (r_state == S_IDLE) && ready_to_draw;
    assign w_pop     = w_idle_go && !w_take_clear && !w_empty;

    draw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_wdata ('{x: req_x, y: req_y, colour: req_colour}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

`ifdef DRAW_QUEUE_CLEAR_EN
    logic r_clr_pend;

    assign w_take_clear = w_idle_go && r_clr_pend;
    assign w_clr_busy   = r_clr_pend;

    // A new request on the consuming edge wins, so a second clear follows.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           r_clr_pend <= 1'b0;
        else if (clear_req)    r_clr_pend <= 1'b1;
        else if (w_take_clear) r_clr_pend <= 1'b0;
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = clear_req;
    assign w_take_clear   = 1'b0;
    assign w_clr_busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_clear) w_next_state = S_ISSUE_CLEAR;
                else if (w_pop)   w_next_state = S_ISSUE_BLOCK;
            end
            S_ISSUE_BLOCK, S_ISSUE_CLEAR: w_next_state = S_WAIT_ACK;
            S_WAIT_ACK:  if (!ready_to_draw) w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (ready_to_draw)  w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        enable_start = (r_state == S_ISSUE_BLOCK);
`ifdef DRAW_QUEUE_CLEAR_EN
        enable_clear = (r_state == S_ISSUE_CLEAR);
`else
        enable_clear = 1'b0;
`endif
        busy = (r_state != S_IDLE) || (count != '0) || w_clr_busy;
    end

    // Draw coordinates only move on a block pop; clears leave them alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else if (w_pop) begin
            x      <= w_head.x;
            y      <= w_head.y;
            colour <= w_head.colour;
        end
    end
endmodule

// File: tb/tb_draw_request_queue.sv
// Randomised bench for draw_request_queue against a transaction-level queue model.
module tb_draw_request_queue;
    localparam int DEPTH = 4;
`ifdef DRAW_QUEUE_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = '0;
    logic [6:0] req_y = '0;
    logic [2:0] req_colour = '0;
    logic       clear_req = 1'b0;
    logic       ready_to_draw = 1'b0;
    logic       enable_start;
    logic       enable_clear;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [$clog2(DEPTH):0] count;
    logic       busy;

    draw_request_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .clear_req(clear_req),
        .ready_to_draw(ready_to_draw), .enable_start(enable_start), .enable_clear(enable_clear),
        .x(x), .y(y), .colour(colour), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: request queue, pending-clear bit, and the issue phase
    // (0 idle, 1 block pulse, 2 clear pulse, 3 awaiting ack, 4 awaiting done).
    logic [17:0] mq[$];
    bit          m_clr;
    int          m_ph;
    logic [17:0] m_xyc;
    int          c_dly = 0;
    int          c_lo  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk(input int xx, input int yy, input int cc);
        logic [7:0] a; logic [6:0] b; logic [2:0] c;
        a = 8'(xx); b = 7'(yy); c = 3'(cc);
        return {a, b, c};
    endfunction

    task automatic model_reset();
        mq.delete(); m_clr = 0; m_ph = 0; m_xyc = '0;
    endtask

    task automatic check_outputs();
        chk("enable_start", enable_start, m_ph == 1);
        chk("enable_clear", enable_clear, m_ph == 2);
        chk("x", x, m_xyc[17:10]);
        chk("y", y, m_xyc[9:3]);
        chk("colour", colour, m_xyc[2:0]);
        chk("count", count, mq.size());
        chk("req_ready", req_ready, mq.size() < DEPTH);
        chk("busy", busy, (m_ph != 0) || (mq.size() != 0) || m_clr);
    endtask

    // Check current outputs, drive one cycle of inputs, advance the model across the edge.
    task automatic step(input bit rv, input logic [17:0] d, input bit cr, input bit rdy);
        bit acc, pop, take;
        int nph;
        check_outputs();
        req_valid = rv; {req_x, req_y, req_colour} = d; clear_req = cr; ready_to_draw = rdy;
        acc = rv && (mq.size() < DEPTH);
        pop = 0; take = 0; nph = m_ph;
        case (m_ph)
            0: if (rdy) begin
                   if (m_clr) begin take = 1; nph = 2; end
                   else if (mq.size() > 0) begin pop = 1; nph = 1; end
               end
            1, 2: nph = 3;
            3: if (!rdy) nph = 4;
            4: if (rdy) nph = 0;
            default: nph = 0;
        endcase
        @(posedge clk);
        if (pop) m_xyc = mq.pop_front();
        if (acc) mq.push_back(d);
        if (CLR_EN && cr) m_clr = 1;
        else if (take)    m_clr = 0;
        m_ph = nph;
        @(negedge clk);
    endtask

    // Behavioural plotter: after each pulse, stays ready briefly, drops ready for a while, then returns.
    task automatic ctl_step(input bit rv, input logic [17:0] d, input bit cr);
        bit rdy;
        if (enable_start || enable_clear) begin
            c_dly = $urandom_range(0, 2);
            c_lo  = $urandom_range(1, 5);
        end
        if (c_dly > 0)     begin rdy = 1; c_dly--; end
        else if (c_lo > 0) begin rdy = 0; c_lo--; end
        else               rdy = ($urandom_range(0, 9) != 0);
        step(rv, d, cr, rdy);
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_ph != 0 || mq.size() != 0 || m_clr) && guard < 400) begin
            ctl_step(0, '0, 0);
            guard++;
        end
        chk("drain_bound", guard < 400, 1);
        c_dly = 0; c_lo = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        check_outputs();
        resetn = 1'b1;

        // Single request with an idle controller.
        step(1, mk(10, 20, 3), 0, 1);
        step(0, '0, 0, 1);
        chk("t1_pulse", enable_start, 1);
        chk("t1_x", x, 10);
        step(0, '0, 0, 1);
        chk("t1_pulse_one", enable_start, 0);
        repeat (20) ctl_step(0, '0, 0);
        chk("t1_hold", {x, y, colour}, mk(10, 20, 3));
        drain();

        // Fill past capacity while the controller is busy.
        for (int i = 0; i < 5; i++) step(1, mk(i * 7 + 1, i * 3 + 2, i), 0, 0);
        chk("full_count", count, DEPTH);
        chk("full_ready", req_ready, 0);
        step(1, mk(99, 99, 7), 0, 1);     // pop at full; offered request is refused
        drain();

        // Push and pop on the same edge with count=3.
        for (int i = 0; i < 3; i++) step(1, mk(40 + i, 50 + i, i), 0, 0);
        step(1, mk(77, 66, 5), 0, 1);
        chk("pp_count", count, 3);
        drain();

`ifdef DRAW_QUEUE_CLEAR_EN
        // Clear and block in the same cycle: clear first, coordinates untouched.
        step(1, mk(50, 60, 5), 1, 1);
        step(0, '0, 0, 1);
        chk("clr_first", enable_clear, 1);
        drain();
        // Clear arriving on the consuming edge produces a second clear.
        step(0, '0, 1, 1);
        step(0, '0, 1, 1);
        drain();
`endif

        // Controller stuck busy after ack: no further pulses.
        step(1, mk(3, 4, 6), 0, 1);
        step(1, mk(8, 9, 1), 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, '0, 0, 0);
        drain();

        // Reset while waiting for done with 3 entries queued.
        step(1, mk(11, 12, 2), 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        step(1, mk(21, 22, 3), 0, 0);
        step(1, mk(31, 32, 4), 0, 0);
        step(1, mk(41, 42, 5), 0, 0);
        chk("pre_rst_count", count, 3);
        resetn = 1'b0;
        #1;
        chk("rst_async_count", count, 0);
        chk("rst_async_start", enable_start, 0);
        chk("rst_async_xyc", {x, y, colour}, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ready", req_ready, 1);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) step(0, '0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            ctl_step($urandom_range(0, 1) == 1,
                     mk($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7)),
                     $urandom_range(0, 19) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
